// File: rtl/l1mtx_pkg.sv
// Shared AHB encodings, widths, FSM states and the address/control bundle for the L1 matrix input stage.
package l1mtx_pkg;

    localparam int ADDR_W   = 32;
    localparam int MASTER_W = 4;
    localparam int PROT_W   = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_DATA = 2'b10
    } in_stg_state_e;

    // Everything the decoder and output stages see for one address phase.
    typedef struct packed {
        logic                sel;
        logic [ADDR_W-1:0]   addr;
        logic [1:0]          trans;
        logic                write;
        logic [2:0]          size;
        logic [2:0]          burst;
        logic [PROT_W-1:0]   prot;
        logic [MASTER_W-1:0] master;
        logic                lock;
    } addr_ctl_t;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
    function automatic logic is_xfer(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/l1mtx_in_stg_if.sv
// Master-port bus of the input stage: AHB master side, matrix side and the returned data-phase status.
interface l1mtx_in_stg_if;
    import l1mtx_pkg::*;

    logic                HSELS;
    logic [ADDR_W-1:0]   HADDRS;
    logic [1:0]          HTRANSS;
    logic                HWRITES;
    logic [2:0]          HSIZES;
    logic [2:0]          HBURSTS;
    logic [PROT_W-1:0]   HPROTS;
    logic [MASTER_W-1:0] HMASTERS;
    logic                HMASTLOCKS;
    logic                HREADYS;

    logic                active_in;
    logic                readyout_in;
    logic                resp_in;

    logic                HREADYOUTS;
    logic                HRESPS;

    logic                sel_op;
    logic [ADDR_W-1:0]   addr_op;
    logic [1:0]          trans_op;
    logic                write_op;
    logic [2:0]          size_op;
    logic [2:0]          burst_op;
    logic [PROT_W-1:0]   prot_op;
    logic [MASTER_W-1:0] master_op;
    logic                mastlock_op;
    logic                held_tran_op;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS,
               HMASTLOCKS, HREADYS, active_in, readyout_in, resp_in,
        output HREADYOUTS, HRESPS, sel_op, addr_op, trans_op, write_op, size_op,
               burst_op, prot_op, master_op, mastlock_op, held_tran_op
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS,
               HMASTLOCKS, HREADYS, active_in, readyout_in, resp_in,
        input  HREADYOUTS, HRESPS, sel_op, addr_op, trans_op, write_op, size_op,
               burst_op, prot_op, master_op, mastlock_op, held_tran_op
    );

endinterface

// File: rtl/l1mtx_in_stg.sv
// L1 matrix input stage: granted address phases pass through combinationally (0 cycles), refused ones are held.
// Backpressure: while held, HREADYOUTS=0 to the master; in the data phase the owning output stage's ready/resp are returned.
module l1mtx_in_stg
    import l1mtx_pkg::*;
(
    input  logic            HCLK,
    input  logic            HRESETn,
    l1mtx_in_stg_if.slave   bus
);

    in_stg_state_e r_state;
    in_stg_state_e w_nxt_state;
    addr_ctl_t     r_hold;
    addr_ctl_t     w_live;
    addr_ctl_t     w_ops;

    logic w_new_tran;
    logic w_accept;
    logic w_slot_free;
    logic w_capture;
    logic w_readyout;
    logic w_resp;
    logic w_held_tran;

    assign w_live = '{
        sel:    bus.HSELS,
        addr:   bus.HADDRS,
        trans:  bus.HTRANSS,
        write:  bus.HWRITES,
        size:   bus.HSIZES,
        burst:  bus.HBURSTS,
        prot:   bus.HPROTS,
        master: bus.HMASTERS,
        lock:   bus.HMASTLOCKS
    };

    assign w_new_tran = bus.HSELS & bus.HREADYS & is_xfer(bus.HTRANSS);
    assign w_accept   = bus.active_in & bus.readyout_in;

    // A retiring data phase frees the port in the same cycle, so the next address phase needs no bubble.
    assign w_slot_free = (r_state == ST_IDLE) || ((r_state == ST_DATA) && bus.readyout_in);
    assign w_capture   = w_slot_free & w_new_tran & ~w_accept;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        unique case (r_state)
            ST_HELD: begin
                if (w_accept) begin
                    w_nxt_state = ST_DATA;
                end
            end
            ST_IDLE, ST_DATA: begin
                if (w_slot_free) begin
                    if (w_new_tran) begin
                        w_nxt_state = w_accept ? ST_DATA : ST_HELD;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= w_live;
        end
    end

    always_comb begin
        w_ops       = w_live;
        w_readyout  = 1'b1;
        w_resp      = HRESP_OKAY;
        w_held_tran = w_new_tran;
        unique case (r_state)
            ST_HELD: begin
                w_ops       = r_hold;
                w_readyout  = 1'b0;
                w_held_tran = 1'b1;
            end
            ST_DATA: begin
                w_readyout = bus.readyout_in;
                w_resp     = bus.resp_in;
            end
            default: ;
        endcase
    end

    assign bus.HREADYOUTS   = w_readyout;
    assign bus.HRESPS       = w_resp;
    assign bus.held_tran_op = w_held_tran;
    assign bus.sel_op       = w_ops.sel;
    assign bus.addr_op      = w_ops.addr;
    assign bus.trans_op     = w_ops.trans;
    assign bus.write_op     = w_ops.write;
    assign bus.size_op      = w_ops.size;
    assign bus.burst_op     = w_ops.burst;
    assign bus.prot_op      = w_ops.prot;
    assign bus.master_op    = w_ops.master;
    assign bus.mastlock_op  = w_ops.lock;

endmodule
